// File: rtl/dcache_controller.sv
// ============================================================================
// Module   : dcache_controller
// Purpose  : Miss-sequencing FSM for a direct-mapped L1 data cache. It runs
//            writeback/refill bursts against L2 and keeps hit/miss statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

module dcache_controller
    import dcache_pkg::*;
#(
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_req_valid,
    output logic                  pipe_stall,
    input  logic                  hit,
    input  logic                  clean_miss,
    input  logic                  dirty_miss,
    input  logic                  counter_done,
    output logic                  l2_req_valid,
    output memory_operation_e     l2_req_type,
    input  logic                  l2_fulfilled,
    output logic                  flush_mode,
    output logic                  load_mode,
    output logic                  clear_selected_dirty_bit,
    output logic                  clear_selected_valid_bit,
    output logic                  finish_new_line_install,
    output logic                  set_new_l2_block_address,
    output logic                  reset_counter,
    output logic                  decrement_counter,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count,
    output logic [STAT_WIDTH-1:0] writeback_count
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_FLUSH        = 2'd1,
        S_REFILL_SETUP = 2'd2,
        S_LOAD         = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_refilled;
    logic                  w_lookup_ok;
    logic                  w_hit_evt;
    logic                  w_miss_evt;
    logic                  w_wb_evt;
    logic                  w_load_last;
    logic [STAT_WIDTH-1:0] r_hit_count;
    logic [STAT_WIDTH-1:0] r_miss_count;
    logic [STAT_WIDTH-1:0] r_wb_count;

    assign w_lookup_ok = pipe_req_valid && $onehot({hit, clean_miss, dirty_miss});
    assign w_load_last = (r_state == S_LOAD) && l2_fulfilled && counter_done;
    assign pipe_stall  = (r_state != S_IDLE) || (pipe_req_valid && !hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_refilled <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_refilled <= w_load_last;
        end
    end

    always_comb begin
        w_state_next             = r_state;
        l2_req_valid             = 1'b0;
        l2_req_type              = LOAD;
        flush_mode               = 1'b0;
        load_mode                = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        clear_selected_valid_bit = 1'b0;
        finish_new_line_install  = 1'b0;
        set_new_l2_block_address = 1'b0;
        reset_counter            = 1'b0;
        decrement_counter        = 1'b0;
        w_hit_evt                = 1'b0;
        w_miss_evt               = 1'b0;
        w_wb_evt                 = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The hit that ends a refill belongs to an already-counted miss.
                if (!reset && w_lookup_ok) begin
                    if (hit) begin
                        w_hit_evt = !r_refilled;
                    end else if (clean_miss) begin
                        set_new_l2_block_address = 1'b1;
                        reset_counter            = 1'b1;
                        clear_selected_valid_bit = 1'b1;
                        w_miss_evt               = 1'b1;
                        w_state_next             = S_LOAD;
                    end else begin
                        set_new_l2_block_address = 1'b1;
                        reset_counter            = 1'b1;
                        w_miss_evt               = 1'b1;
                        w_wb_evt                 = 1'b1;
                        w_state_next             = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                flush_mode   = 1'b1;
                l2_req_valid = 1'b1;
                l2_req_type  = STORE;
                if (l2_fulfilled) begin
                    if (counter_done) begin
                        clear_selected_dirty_bit = 1'b1;
                        clear_selected_valid_bit = 1'b1;
                        w_state_next             = S_REFILL_SETUP;
                    end else begin
                        decrement_counter = 1'b1;
                    end
                end
            end
            S_REFILL_SETUP: begin
                set_new_l2_block_address = 1'b1;
                reset_counter            = 1'b1;
                w_state_next             = S_LOAD;
            end
            S_LOAD: begin
                load_mode    = 1'b1;
                l2_req_valid = 1'b1;
                l2_req_type  = LOAD;
                if (l2_fulfilled) begin
                    if (counter_done) begin
                        finish_new_line_install  = 1'b1;
                        clear_selected_dirty_bit = 1'b1;
                        w_state_next             = S_IDLE;
                    end else begin
                        decrement_counter = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Saturating statistics: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (w_hit_evt && !(&r_hit_count)) begin
                r_hit_count <= r_hit_count + STAT_WIDTH'(1);
            end
            if (w_miss_evt && !(&r_miss_count)) begin
                r_miss_count <= r_miss_count + STAT_WIDTH'(1);
            end
            if (w_wb_evt && !(&r_wb_count)) begin
                r_wb_count <= r_wb_count + STAT_WIDTH'(1);
            end
        end
    end

    assign hit_count       = r_hit_count;
    assign miss_count      = r_miss_count;
    assign writeback_count = r_wb_count;

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================================
// Module   : tb_dcache_controller
// Purpose  : Scoreboard bench for dcache_controller with a one-line cache,
//            word-counter and L2 responder model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int SW  = 4;
    localparam int SAT = (1 << SW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic pipe_req_valid, pipe_stall;
    logic hit, clean_miss, dirty_miss, counter_done;
    logic l2_req_valid, l2_fulfilled;
    memory_operation_e l2_req_type;
    logic flush_mode, load_mode, clear_selected_dirty_bit, clear_selected_valid_bit;
    logic finish_new_line_install, set_new_l2_block_address, reset_counter, decrement_counter;
    logic [SW-1:0] hit_count, miss_count, writeback_count;

    dcache_controller #(.STAT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .pipe_req_valid(pipe_req_valid), .pipe_stall(pipe_stall),
        .hit(hit), .clean_miss(clean_miss), .dirty_miss(dirty_miss),
        .counter_done(counter_done),
        .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type), .l2_fulfilled(l2_fulfilled),
        .flush_mode(flush_mode), .load_mode(load_mode),
        .clear_selected_dirty_bit(clear_selected_dirty_bit),
        .clear_selected_valid_bit(clear_selected_valid_bit),
        .finish_new_line_install(finish_new_line_install),
        .set_new_l2_block_address(set_new_l2_block_address),
        .reset_counter(reset_counter), .decrement_counter(decrement_counter),
        .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-line cache model; preload overrides the DUT-driven updates.
    logic       line_valid, line_dirty;
    logic [7:0] line_tag, req_tag;
    logic       preload, pl_valid, pl_dirty;
    logic [7:0] pl_tag;
    always @(posedge clk) begin
        if (preload) begin
            line_valid <= pl_valid;
            line_dirty <= pl_dirty;
            line_tag   <= pl_tag;
        end else begin
            if (clear_selected_valid_bit) line_valid <= 1'b0;
            if (clear_selected_dirty_bit) line_dirty <= 1'b0;
            if (finish_new_line_install) begin
                line_valid <= 1'b1;
                line_tag   <= req_tag;
            end
        end
    end
    assign hit        = pipe_req_valid & line_valid & (line_tag == req_tag);
    assign dirty_miss = pipe_req_valid & line_valid & line_dirty & (line_tag != req_tag);
    assign clean_miss = pipe_req_valid & ~hit & ~dirty_miss;

    logic [2:0] wcnt;
    always @(posedge clk or posedge reset) begin
        if (reset)                  wcnt <= 3'd0;
        else if (reset_counter)     wcnt <= 3'd7;
        else if (decrement_counter) wcnt <= wcnt - 3'd1;
    end
    assign counter_done = (wcnt == 3'd0);

    int l2_period;
    int wait_ctr;
    assign l2_fulfilled = l2_req_valid && (wait_ctr == l2_period - 1);
    always @(posedge clk or posedge reset) begin
        if (reset)                               wait_ctr <= 0;
        else if (!l2_req_valid || l2_fulfilled) wait_ctr <= 0;
        else                                     wait_ctr <= wait_ctr + 1;
    end

    typedef struct packed {
        memory_operation_e typ;
        logic dec, fin, cdirty, cvalid;
    } beat_t;
    typedef struct {
        int hits, misses, wbs, lat, l2cyc, setnew;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    int checks = 0, failures = 0;
    int req_cyc, l2cyc_acc, setnew_acc;
    int exp_hits, exp_miss, exp_wb;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    // Monitor: pops expectations whenever the DUT completes a beat or a request.
    always @(negedge clk) begin : monitor
        beat_t b;
        done_t d;
        if (reset) begin
            l2cyc_acc  = 0;
            setnew_acc = 0;
        end else begin
            if (l2_req_valid) l2cyc_acc++;
            if (set_new_l2_block_address) setnew_acc++;
            if (l2_req_valid && l2_fulfilled) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_type", l2_req_type, b.typ);
                    chk("beat_flush_mode", flush_mode, b.typ == STORE);
                    chk("beat_load_mode", load_mode, b.typ == LOAD);
                    chk("beat_decrement", decrement_counter, b.dec);
                    chk("beat_finish", finish_new_line_install, b.fin);
                    chk("beat_clr_dirty", clear_selected_dirty_bit, b.cdirty);
                    chk("beat_clr_valid", clear_selected_valid_bit, b.cvalid);
                end
            end else if (l2_req_valid) begin
                chk("wait_decrement", decrement_counter, 0);
                chk("wait_finish", finish_new_line_install, 0);
                chk("wait_mode", flush_mode ^ load_mode, 1);
            end
            if (pipe_req_valid && !pipe_stall) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_accept", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("acc_hit_count", hit_count, d.hits);
                    chk("acc_miss_count", miss_count, d.misses);
                    chk("acc_wb_count", writeback_count, d.wbs);
                    chk("acc_latency", cyc - req_cyc + 1, d.lat);
                    chk("acc_l2_cycles", l2cyc_acc, d.l2cyc);
                    chk("acc_set_addr_pulses", setnew_acc, d.setnew);
                end
                l2cyc_acc  = 0;
                setnew_acc = 0;
            end
        end
    end

    task automatic push_beats(input memory_operation_e t, input int n);
        for (int i = 0; i < n; i++) begin
            beat_q.push_back('{typ: t, dec: (i < 7), fin: (t == LOAD && i == 7),
                               cdirty: (i == 7), cvalid: (t == STORE && i == 7)});
        end
    endtask

    task automatic do_preload(input logic v, input logic dty, input logic [7:0] tag);
        @(posedge clk); #2;
        preload = 1'b1; pl_valid = v; pl_dirty = dty; pl_tag = tag;
        @(posedge clk); #2;
        preload = 1'b0;
    endtask

    // kind: 0 = hit, 1 = clean miss, 2 = dirty miss
    task automatic issue(input logic [7:0] tag, input int kind);
        done_t d;
        bit    ok;
        if (kind == 0) begin
            d = '{exp_hits, exp_miss, exp_wb, 1, 0, 0};
            exp_hits = sat_inc(exp_hits);
        end else if (kind == 1) begin
            exp_miss = sat_inc(exp_miss);
            push_beats(LOAD, 8);
            d = '{exp_hits, exp_miss, exp_wb, 2 + 8 * l2_period, 8 * l2_period, 1};
        end else begin
            exp_miss = sat_inc(exp_miss);
            exp_wb   = sat_inc(exp_wb);
            push_beats(STORE, 8);
            push_beats(LOAD, 8);
            d = '{exp_hits, exp_miss, exp_wb, 3 + 16 * l2_period, 16 * l2_period, 2};
        end
        done_q.push_back(d);
        @(posedge clk); #2;
        req_tag = tag; pipe_req_valid = 1'b1; req_cyc = cyc;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pipe_stall) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("request_timeout", 1, 0);
            beat_q.delete();
            done_q.delete();
        end
        @(posedge clk); #2;
        pipe_req_valid = 1'b0;
        chk("leftover_beats", beat_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pipe_req_valid = 1'b0; req_tag = 8'h00;
        preload = 1'b0; pl_valid = 1'b0; pl_dirty = 1'b0; pl_tag = 8'h00;
        l2_period = 1; exp_hits = 0; exp_miss = 0; exp_wb = 0; req_cyc = 0;
        #2;
        chk("rst_pipe_stall", pipe_stall, 0);
        chk("rst_l2_req_valid", l2_req_valid, 0);
        chk("rst_set_addr", set_new_l2_block_address, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_wb_count", writeback_count, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        do_preload(1'b1, 1'b0, 8'hA0);
        issue(8'hA0, 0);
        issue(8'hB1, 1);
        do_preload(1'b1, 1'b1, 8'hB1);
        issue(8'hC2, 2);
        l2_period = 3;
        issue(8'hD3, 1);
        l2_period = 1;

        // Reset lands mid-refill on the fourth LOAD beat.
        push_beats(LOAD, 3);
        @(posedge clk); #2;
        req_tag = 8'hE4; pipe_req_valid = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_l2_valid", l2_req_valid, 1);
        reset = 1'b1;
        #1;
        chk("reset_l2_valid", l2_req_valid, 0);
        chk("reset_load_mode", load_mode, 0);
        chk("reset_finish", finish_new_line_install, 0);
        chk("reset_miss_count", miss_count, 0);
        chk("reset_wb_count", writeback_count, 0);
        pipe_req_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("reset_beats_left", beat_q.size(), 0);
        beat_q.delete();
        exp_hits = 0; exp_miss = 0; exp_wb = 0;

        issue(8'hE4, 1);
        for (int i = 0; i < SAT + 2; i++) issue(8'hE4, 0);
        @(negedge clk);
        chk("sat_hit_count", hit_count, SAT);
        chk("final_miss_count", miss_count, 1);
        chk("final_wb_count", writeback_count, 0);
        chk("final_done_queue", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Sequencing FSM for the direct-mapped L1 data cache datapath. It watches the pipeline request and the datapath's hit/miss flags. On a miss it runs the line writeback (flush) and line refill (load) sequences word-by-word against L2, using the datapath's word counter and steering controls. It stalls the pipeline until the requested line is resident, and keeps saturating hit/miss/writeback statistics.

## Interface
- STAT_WIDTH, 32, width of each statistics counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pipe_req_valid  in  1  pipeline request present; request fields held stable while pipe_stall=1
- pipe_stall  out  1  pipeline must hold its request
- hit, clean_miss, dirty_miss  in  1 each  datapath lookup result (one-hot when pipe_req_valid=1)
- counter_done  in  1  datapath word counter == 0
- l2_req_valid  out  1  L2 word transfer requested
- l2_req_type  out  memory_operation_e  LOAD (refill) or STORE (writeback)
- l2_fulfilled  in  1  L2 completed the current word this cycle
- flush_mode, load_mode  out  1 each  datapath steering
- clear_selected_dirty_bit, clear_selected_valid_bit  out  1 each
- finish_new_line_install, set_new_l2_block_address  out  1 each
- reset_counter, decrement_counter  out  1 each
- hit_count, miss_count, writeback_count  out  STAT_WIDTH each  statistics

## Operation
- States: IDLE, FLUSH, REFILL_SETUP, LOAD. All outputs are Moore outputs or decodes of the state plus the current-cycle inputs listed below.
- IDLE, pipe_req_valid=0: no outputs asserted.
- IDLE, hit=1: stay in IDLE. The datapath serves the request. hit_count increments.
- IDLE, clean_miss=1: assert set_new_l2_block_address, reset_counter and clear_selected_valid_bit, then go to LOAD. miss_count increments.
- IDLE, dirty_miss=1: assert set_new_l2_block_address (latches the victim tag) and reset_counter, then go to FLUSH. miss_count and writeback_count increment.
- FLUSH: flush_mode=1, l2_req_valid=1, l2_req_type=STORE.
  - On l2_fulfilled with counter_done=0: assert decrement_counter.
  - On l2_fulfilled with counter_done=1: assert clear_selected_dirty_bit and clear_selected_valid_bit, then go to REFILL_SETUP.
- REFILL_SETUP (1 cycle): the line now reads as a clean miss. Assert set_new_l2_block_address (latches the request tag) and reset_counter, then go to LOAD.
- LOAD: load_mode=1, l2_req_valid=1, l2_req_type=LOAD. The datapath writes l2_fetched_word on every l2_fulfilled.
  - On l2_fulfilled with counter_done=0: assert decrement_counter.
  - On l2_fulfilled with counter_done=1: assert finish_new_line_install and clear_selected_dirty_bit, then go to IDLE.
- pipe_stall = (state != IDLE) | (pipe_req_valid & ~hit).
- hit/clean_miss/dirty_miss are sampled only in IDLE. They are ignored in all other states.
- Once a miss sequence starts it always completes, even if pipe_req_valid drops. The line is installed for the latched set/tag.
- Statistics counters saturate at all-ones and never wrap. Each increments at most once per accepted request. A request that misses is counted only as a miss, not also as a hit when it completes after refill.
- If hit/clean_miss/dirty_miss are not one-hot while pipe_req_valid=1 in IDLE: stay in IDLE, assert no control outputs. The bench flags this as an assertion error.

## Timing
- Reset (asynchronous): state=IDLE, every control output=0 and all statistics=0, immediately and without waiting for a clock edge. pipe_stall then follows its combinational equation.
- Reset mid-sequence: l2_req_valid drops at once and the partial line is abandoned. The line's valid bit is already 0 (clean miss) or still dirty/valid (flush), so the cache stays coherent.
- L2 handshake:
  - l2_req_valid stays high with stable l2_req_type until l2_fulfilled is seen.
  - The address advances on the edge after each fulfilled beat.
  - l2_fulfilled may arrive in the first cycle of a state and on consecutive cycles (one word per cycle).
  - l2_fulfilled is ignored when l2_req_valid=0.
- Latency, XLEN=32 and 32-byte lines (8 words), L2 fulfilling every cycle:
  - Clean miss: 1 IDLE cycle + 8 LOAD cycles. The hit is seen in the 10th cycle after the request.
  - Dirty miss: 1 IDLE + 8 FLUSH + 1 REFILL_SETUP + 8 LOAD. The hit is seen in the 19th cycle.
- L2 wait states extend FLUSH/LOAD one cycle per stall cycle. The control outputs stay constant during a wait state; decrement_counter=0.

## Test plan
- Reset, then LOAD hit on a valid line -> pipe_stall=0, no L2 activity, hit_count=1, miss_count=0.
- Clean miss, L2 fulfilling every cycle:
  - required: l2_req_valid high for exactly 8 cycles with l2_req_type=LOAD, 7 decrement_counter pulses, one finish_new_line_install pulse on beat 8;
  - the next cycle shows hit=1 and pipe_stall=0.
- Dirty miss:
  - required: 8 STORE beats, then 1 REFILL_SETUP cycle with set_new_l2_block_address=1, then 8 LOAD beats;
  - writeback_count=1 and miss_count=1.
- Clean miss with L2 asserting l2_fulfilled every 3rd cycle -> LOAD lasts 24 cycles, outputs stable between beats.
- Async reset asserted on LOAD beat 4 -> l2_req_valid=0 in the same cycle and state=IDLE. Re-issuing the request gives a fresh clean miss with 8 beats.
- Force hit_count to all-ones minus 1, then issue 3 hits -> hit_count holds all-ones.
